sub_cmp_serial: RTL
===================

// Module: sub_cmp_serial
// PURPOSE
//  Parametrised digit-serial subtractor/comparator: computes Q = A - B - borrow_in on WIDTH-bit operands.
//  Processes DIGIT bits per clock, LSB digit first, with a registered borrow chain.
//  Also produces equal/less/greater flags. Sits behind the number-compare/counter datapath and replaces
//  fixed 4-bit ripple subtractors where width must scale and area matters more than latency.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT   4  bits processed per cycle; 1 <= DIGIT <= WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands offered
//  in_ready   out  1      block can accept operands (IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  borrow_in  in   1      borrow into LSB digit
//  out_valid  out  1      result held and valid
//  out_ready  in   1      consumer accepts result
//  q          out  WIDTH  difference A - B - borrow_in, modulo 2^WIDTH
//  borrow_out out  1      borrow out of MSB (1 when A < B + borrow_in, unsigned)
//  eq/lt/gt   out  1 each compare of A vs B (borrow_in ignored); exactly one set when out_valid
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, q=0, borrow_out=0, eq/lt/gt=0.
//  - Per-bit rule: d = a^b^c; c_next = (b&c) | (~a&(b^c)). Digit slice chains DIGIT bits combinationally.
//  - FSM IDLE -> RUN on in_valid&&in_ready: latch a, b; borrow reg <= borrow_in; cmp_borrow <= 0; zero <= 1; cnt <= 0.
//  - RUN: each cycle process digit cnt. Write the difference digit into q[cnt*DIGIT +: DIGIT].
//    Update the borrow reg. Update cmp_borrow via a parallel chain with borrow_in=0.
//    Clear zero if the A and B digits differ. cnt++.
//  - RUN -> DONE after digit WIDTH/DIGIT-1. Latency is exactly WIDTH/DIGIT+1 cycles from accept to out_valid.
//  - DONE: out_valid=1; outputs stable until out_ready. eq=zero, lt=cmp_borrow, gt=~zero&~cmp_borrow.
//    On out_valid&&out_ready -> IDLE, out_valid=0 next cycle. q/flags hold last values (not cleared).
//  - in_ready=1 only in IDLE. No accept in the same cycle as the result handshake (no overlap).
//  - in_valid in RUN/DONE is ignored; operand registers are not modified. out_ready outside DONE is ignored.
//  - WIDTH==DIGIT: single RUN cycle, latency 2. cnt width = $clog2(WIDTH/DIGIT), min 1; no wrap beyond last digit.
//  - Reset mid-RUN/DONE: result discarded, immediate return to reset values.
// CONFIGURATION
//  - SUB_CMP_SIGNED_EN defined: lt/gt report a two's-complement compare. lt = sign(A)^sign(B) ? sign(A) : cmp_borrow.
//    Adds output ovf (1 = signed overflow of A-B-borrow_in), reset 0, valid with out_valid.
//  - Not defined: lt/gt are unsigned; no ovf port.
// STRUCTURE
//  - Package sub_cmp_pkg: state enum {S_IDLE,S_RUN,S_DONE}; function nbits(x) for counter width.
//  - Sub-module sub_digit #(DIGIT): combinational slice (a_d, b_d, c_in -> d, c_out).
//    Instantiate twice: the result chain and the compare chain (c_in tied to the compare borrow reg).
//  - Elaboration check: WIDTH % DIGIT == 0, else $error.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//  - a=0x1234 b=0x0234 bin=0 -> q=0x1000 bout=0 gt=1. out_valid exactly 5 cycles after accept.
//  - a=0x0000 b=0x0001 bin=0 -> q=0xFFFF bout=1 lt=1. a=b=0x0005 bin=1 -> q=0xFFFF bout=1 eq=1.
//  - out_ready held 0 for 10 cycles in DONE -> q/flags stable, in_ready=0. New in_valid is ignored.
//  - rst pulsed after 2 RUN cycles -> all outputs at reset values, in_ready=1. The next op computes correctly.
//  - WIDTH=8 DIGIT=8: a=0x80 b=0x7F bin=0 -> q=0x01 bout=0 gt=1, latency 2.
//  - SUB_CMP_SIGNED_EN: a=0x8000 b=0x0001 -> q=0x7FFF lt=1 ovf=1. Without the macro -> gt=1, bout=0.

Source files
------------

// File: rtl/sub_cmp_pkg.sv
// Shared definitions for the digit-serial subtractor/comparator.
//   state_t : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   nbits() : width of a counter that indexes x digits, never below 1 bit
package sub_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int nbits(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/sub_cmp_serial_digit.sv
// sub_digit: combinational DIGIT-bit borrow-ripple subtract slice.
//   a_d, b_d : minuend / subtrahend digit
//   c_in     : borrow into the digit LSB
//   d        : difference digit a_d - b_d - c_in
//   c_out    : borrow out of the digit MSB
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] d,
    output logic             c_out
);

    always_comb begin
        logic c;
        c = c_in;
        d = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = a_d[i] ^ b_d[i] ^ c;
            c    = (b_d[i] & c) | (~a_d[i] & (b_d[i] ^ c));
        end
        c_out = c;
    end

endmodule

// File: rtl/sub_cmp_serial.sv
// sub_cmp_serial: digit-serial Q = A - B - borrow_in with eq/lt/gt compare flags.
// One DIGIT-wide digit is processed per clock, LSB first; the borrow between
// digits is carried in a register.
//
// Optional feature macro: SUB_CMP_SIGNED_EN -- signed lt/gt plus an ovf output.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, borrow_in)
//   out_valid / out_ready result handshake (q, borrow_out, eq, lt, gt[, ovf])
//   dbg_state             current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in S_IDLE, out_valid only in S_DONE, so an operand
// accept never coincides with a result handshake. The result outputs stay
// stable while out_valid is high and keep their values after the handshake.
module sub_cmp_serial
    import sub_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             borrow_out,
    output logic             eq,
    output logic             lt,
    output logic             gt,
`ifdef SUB_CMP_SIGNED_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = nbits(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_cfg
        $error("sub_cmp_serial: WIDTH must be a nonzero multiple of DIGIT");
    end

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r, q_r;
    logic             borrow_r, cmp_borrow_r, zero_r;
    logic [CW-1:0]    cnt;
    logic             borrow_out_r, eq_r, lt_r, gt_r;

    logic [DIGIT-1:0] a_d, b_d, d_res, d_cmp;
    logic             c_res, c_cmp;
    logic             zero_nx, lt_nx;

    // Digit select by comparing cnt against each constant digit position.
    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                a_d = a_r[i*DIGIT +: DIGIT];
                b_d = b_r[i*DIGIT +: DIGIT];
            end
        end
    end

    sub_digit #(.DIGIT(DIGIT)) u_res (
        .a_d   (a_d),
        .b_d   (b_d),
        .c_in  (borrow_r),
        .d     (d_res),
        .c_out (c_res)
    );

    // Compare chain: same operands with no external borrow, i.e. plain A - B.
    sub_digit #(.DIGIT(DIGIT)) u_cmp (
        .a_d   (a_d),
        .b_d   (b_d),
        .c_in  (cmp_borrow_r),
        .d     (d_cmp),
        .c_out (c_cmp)
    );

    // A - B is zero modulo 2^WIDTH exactly when A == B, so equality is
    // tracked as "every compare-chain difference digit was zero".
    assign zero_nx = zero_r & (d_cmp == '0);

`ifdef SUB_CMP_SIGNED_EN
    // Opposite signs decide directly; same signs fall back to the borrow.
    assign lt_nx = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? a_r[WIDTH-1] : c_cmp;

    logic ovf_r, ovf_nx;
    // Overflow: operand signs differ and the result sign differs from A.
    assign ovf_nx = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_res[DIGIT-1] ^ a_r[WIDTH-1]);
    assign ovf    = ovf_r;
`else
    assign lt_nx = c_cmp;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)     state_nx = S_RUN;
            S_RUN:   if (cnt == LAST)  state_nx = S_DONE;
            S_DONE:  if (out_ready)    state_nx = S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            q_r          <= '0;
            borrow_r     <= 1'b0;
            cmp_borrow_r <= 1'b0;
            zero_r       <= 1'b1;
            cnt          <= '0;
            borrow_out_r <= 1'b0;
            eq_r         <= 1'b0;
            lt_r         <= 1'b0;
            gt_r         <= 1'b0;
`ifdef SUB_CMP_SIGNED_EN
            ovf_r        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r          <= a;
                        b_r          <= b;
                        borrow_r     <= borrow_in;
                        cmp_borrow_r <= 1'b0;
                        zero_r       <= 1'b1;
                        cnt          <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (cnt == CW'(i)) q_r[i*DIGIT +: DIGIT] <= d_res;
                    end
                    borrow_r     <= c_res;
                    cmp_borrow_r <= c_cmp;
                    zero_r       <= zero_nx;
                    if (cnt == LAST) begin
                        // Flags are captured here so they hold after the handshake.
                        borrow_out_r <= c_res;
                        eq_r         <= zero_nx;
                        lt_r         <= lt_nx;
                        gt_r         <= ~zero_nx & ~lt_nx;
`ifdef SUB_CMP_SIGNED_EN
                        ovf_r        <= ovf_nx;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign q          = q_r;
    assign borrow_out = borrow_out_r;
    assign eq         = eq_r;
    assign lt         = lt_r;
    assign gt         = gt_r;
    assign dbg_state  = state;

endmodule
